// File: rtl/mem_rw_pkg.sv
// +------------------------------------------------------------------------+
// | mem_rw_pkg : shared widths, response tuple and sizing helper for mem_rw |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
`default_nettype none

package mem_rw_pkg;

  localparam int c_ADDR_W = 4;
  localparam int c_DATA_W = 32;

  typedef struct packed {
    logic [c_DATA_W-1:0] data;
    logic [c_ADDR_W-1:0] addr;
    logic                err;
  } rsp_t;

  // Width of a counter that must reach depth itself (not depth-1).
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_rw_ctrl_if.sv
// +------------------------------------------------------------------------+
// | mem_rw_ctrl_if : request/response bus of mem_rw_ctrl                    |
// | Revision       : 1.0                                                    |
// +------------------------------------------------------------------------+
`default_nettype none

interface mem_rw_ctrl_if
  import mem_rw_pkg::*;
#(
  parameter int ADDR_W    = c_ADDR_W,
  parameter int DATA_W    = c_DATA_W,
  parameter int RSP_DEPTH = 4
);

  localparam int c_CNT_W = cnt_width(RSP_DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic [c_CNT_W-1:0] rd_outstanding;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_err, rd_outstanding
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_err, rd_outstanding
  );

endinterface

`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
// +------------------------------------------------------------------------+
// | mem_rsp_fifo : synchronous FIFO of read-response tuples                 |
// | Revision     : 1.0                                                      |
// +------------------------------------------------------------------------+
`default_nettype none

module mem_rsp_fifo
  import mem_rw_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type T_ENTRY = rsp_t,
  parameter int  CNT_W   = cnt_width(DEPTH)
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_push,
  input  wire T_ENTRY     i_data,
  input  wire logic       i_pop,
  output T_ENTRY          o_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

  T_ENTRY             r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Explicit wrap compare keeps non-power-of-two depths correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_rw_ctrl.sv
// +------------------------------------------------------------------------+
// | mem_rw_ctrl : memory array, fixed read latency, credit-limited reads;   |
// |               MEM_RW_CTRL_UNINIT_CHK_EN adds unwritten-read flagging    |
// | Revision    : 1.0                                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module mem_rw_ctrl
  import mem_rw_pkg::*;
#(
  parameter int ADDR_W    = c_ADDR_W,
  parameter int DATA_W    = c_DATA_W,
  parameter int READ_LAT  = 2,
  parameter int RSP_DEPTH = 4
) (
  input wire logic     clk,
  input wire logic     reset,
  mem_rw_ctrl_if.slave bus
);

  localparam int                 c_WORDS   = 2 ** ADDR_W;
  localparam int                 c_CNT_W   = cnt_width(RSP_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CREDITS = c_CNT_W'(RSP_DEPTH);

  // Same layout as rsp_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } entry_t;

  logic [DATA_W-1:0]  r_mem [c_WORDS];
  logic [c_CNT_W-1:0] r_outstanding;

  logic               w_req_ready;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_rd_err;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [c_CNT_W-1:0] w_fifo_count;
  entry_t             w_rd_entry;
  entry_t             w_push_entry;
  entry_t             w_head;

  // Writes share the credit gate so req_ready never depends on the request type.
  assign w_req_ready = !reset && (r_outstanding < c_CREDITS);
  assign w_wr_acc    = bus.req_valid && w_req_ready && bus.req_write;
  assign w_rd_acc    = bus.req_valid && w_req_ready && !bus.req_write;

  assign w_rd_entry.data = r_mem[bus.req_addr];
  assign w_rd_entry.addr = bus.req_addr;
  assign w_rd_entry.err  = w_rd_err;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[bus.req_addr] <= bus.req_wdata;
    end
  end

`ifdef MEM_RW_CTRL_UNINIT_CHK_EN
  logic [c_WORDS-1:0] r_written;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_written <= '0;
    end else if (w_wr_acc) begin
      r_written[bus.req_addr] <= 1'b1;
    end
  end

  assign w_rd_err = !r_written[bus.req_addr];
`else
  assign w_rd_err = 1'b0;
`endif

  generate
    if (READ_LAT > 1) begin : g_pipe
      localparam int c_STAGES = READ_LAT - 1;

      logic [c_STAGES-1:0] r_stg_vld;
      entry_t              r_stg [c_STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_stg_vld <= '0;
        end else begin
          r_stg_vld[0] <= w_rd_acc;
          for (int i = 1; i < c_STAGES; i++) begin
            r_stg_vld[i] <= r_stg_vld[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_stg[0] <= w_rd_entry;
        for (int i = 1; i < c_STAGES; i++) begin
          r_stg[i] <= r_stg[i-1];
        end
      end

      assign w_push       = r_stg_vld[c_STAGES-1];
      assign w_push_entry = r_stg[c_STAGES-1];
    end else begin : g_direct
      assign w_push       = w_rd_acc;
      assign w_push_entry = w_rd_entry;
    end
  endgenerate

  mem_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .T_ENTRY (entry_t),
    .CNT_W   (c_CNT_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_pop = !w_fifo_empty && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else if (w_rd_acc && !w_pop) begin
      r_outstanding <= r_outstanding + c_CNT_W'(1);
    end else if (!w_rd_acc && w_pop) begin
      r_outstanding <= r_outstanding - c_CNT_W'(1);
    end
  end

  // Response outputs read as zero whenever nothing is being presented.
  assign bus.req_ready      = w_req_ready;
  assign bus.rsp_valid      = !w_fifo_empty;
  assign bus.rsp_rdata      = w_fifo_empty ? '0 : w_head.data;
  assign bus.rsp_addr       = w_fifo_empty ? '0 : w_head.addr;
  assign bus.rsp_err        = w_fifo_empty ? 1'b0 : w_head.err;
  assign bus.rd_outstanding = r_outstanding;

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(w_push && w_fifo_full && !w_pop));

  a_fifo_bound : assert property (@(posedge clk) disable iff (reset)
    w_fifo_count <= r_outstanding);

endmodule

`default_nettype wire

// File: tb/tb_mem_rw_ctrl.sv
// +------------------------------------------------------------------------+
// | tb_mem_rw_ctrl : scoreboard bench with a behavioural memory model       |
// | Revision       : 1.0                                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_mem_rw_ctrl;

  localparam int c_AW    = 4;
  localparam int c_DW    = 32;
  localparam int c_LAT   = 2;
  localparam int c_DEPTH = 4;
`ifdef MEM_RW_CTRL_UNINIT_CHK_EN
  localparam bit c_CHK_EN = 1'b1;
`else
  localparam bit c_CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [c_DW-1:0] data;
    logic [c_AW-1:0] addr;
    logic            err;
    bit              known;
    bit              exact;
    int              acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   policy = 1;
  int   m_out = 0;
  int   n_rd_acc = 0;
  bit   head_seen = 1'b0;
  bit   t3_done = 1'b0;
  exp_t q[$];

  logic [c_DW-1:0]    m_mem     [2**c_AW];
  bit                 m_known   [2**c_AW];
  bit                 m_written [2**c_AW];

  mem_rw_ctrl_if #(.ADDR_W(c_AW), .DATA_W(c_DW), .RSP_DEPTH(c_DEPTH)) bus ();

  mem_rw_ctrl #(
    .ADDR_W    (c_AW),
    .DATA_W    (c_DW),
    .READ_LAT  (c_LAT),
    .RSP_DEPTH (c_DEPTH)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: drives rsp_ready, then samples just before the active edge.
  initial begin
    exp_t e;
    bit   pop;
    bit   rd;
    forever begin
      @(negedge clk);
      #1;
      case (policy)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
      #3;
      if (reset) begin
        q.delete();
        m_out = 0;
        head_seen = 1'b0;
        for (int i = 0; i < 2**c_AW; i++) m_written[i] = 1'b0;
        chk("req_ready_in_reset", 64'(bus.req_ready), 64'd0);
        continue;
      end
      chk("rd_outstanding", 64'(bus.rd_outstanding), 64'(m_out));
      chk("req_ready", 64'(bus.req_ready), 64'(m_out < c_DEPTH));
      pop = 1'b0;
      rd  = 1'b0;
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end else begin
          e = q[0];
          if (!head_seen && e.exact) chk("rsp_latency", 64'(cyc - e.acc), 64'(c_LAT));
          head_seen = 1'b1;
          if (e.known) chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
          chk("rsp_addr", 64'(bus.rsp_addr), 64'(e.addr));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            head_seen = 1'b0;
            pop = 1'b1;
          end
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_write) begin
          m_mem[bus.req_addr]     = bus.req_wdata;
          m_known[bus.req_addr]   = 1'b1;
          m_written[bus.req_addr] = 1'b1;
        end else begin
          e.data  = m_mem[bus.req_addr];
          e.addr  = bus.req_addr;
          e.err   = c_CHK_EN && !m_written[bus.req_addr];
          e.known = m_known[bus.req_addr];
          e.exact = (m_out == 0);
          e.acc   = cyc;
          q.push_back(e);
          rd = 1'b1;
          n_rd_acc++;
        end
      end
      m_out = m_out + int'(rd) - int'(pop);
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic do_req(input bit wr, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
    int t;
    t = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #4;
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      #4;
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL req_accept_timeout: waited %0d cycles, expected < 200", t);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    policy = 1;
    while ((q.size() != 0 || m_out != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses left, expected 0", q.size());
    end
  endtask

  initial begin
    int base;
    int t;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 2**c_AW; i++) begin
      m_known[i]   = 1'b0;
      m_written[i] = 1'b0;
      m_mem[i]     = '0;
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #4;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("reset_rsp_addr", 64'(bus.rsp_addr), 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("reset_rd_outstanding", 64'(bus.rd_outstanding), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);

    // Basic write then read with the consumer always ready.
    policy = 1;
    do_req(1'b1, 4'd1, 32'h1234_5678);
    do_req(1'b0, 4'd1, '0);
    drain();

    // Unwritten read, then the same address after a write.
    do_req(1'b0, 4'd0, '0);
    do_req(1'b1, 4'd0, 32'hA5A5_A5A5);
    do_req(1'b0, 4'd0, '0);
    drain();

    // Credit exhaustion under backpressure.
    policy = 0;
    base = n_rd_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) do_req(1'b0, 4'(i), '0);
        t3_done = 1'b1;
      end
    join_none
    repeat (12) @(negedge clk);
    #4;
    chk("credit_outstanding", 64'(bus.rd_outstanding), 64'(c_DEPTH));
    chk("credit_req_ready", 64'(bus.req_ready), 64'd0);
    chk("credit_accepted", 64'(n_rd_acc - base), 64'(c_DEPTH));
    @(negedge clk);
    policy = 1;
    t = 0;
    while (!t3_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("credit_release_done", 64'(t3_done), 64'd1);
    drain();

    // Back-to-back write then read of the same word.
    do_req(1'b1, 4'd3, 32'hDEAD_BEEF);
    do_req(1'b1, 4'd3, 32'h0000_0001);
    do_req(1'b0, 4'd3, '0);
    drain();

    // Read accept and response pop in the same cycle.
    policy = 0;
    do_req(1'b0, 4'd1, '0);
    do_req(1'b0, 4'd0, '0);
    repeat (4) @(negedge clk);
    policy = 1;
    do_req(1'b0, 4'd3, '0);
    #4;
    chk("same_cycle_outstanding", 64'(bus.rd_outstanding), 64'd2);
    chk("same_cycle_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    drain();

    // Reset with reads in flight; array contents survive.
    do_req(1'b1, 4'd7, 32'h0000_0077);
    do_req(1'b1, 4'd8, 32'h0000_0088);
    policy = 0;
    do_req(1'b0, 4'd7, '0);
    do_req(1'b0, 4'd8, '0);
    do_req(1'b0, 4'd7, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    policy = 1;
    repeat (8) @(negedge clk);
    #4;
    chk("post_reset_outstanding", 64'(bus.rd_outstanding), 64'd0);
    chk("post_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    do_req(1'b0, 4'd7, '0);
    do_req(1'b0, 4'd8, '0);
    drain();

    // Randomized traffic with random backpressure.
    policy = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_req(1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    end
    drain();

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
